// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types and helpers for the masked-SRAM request controller.
// Mask expansion is sized for the widest supported word.
package hpdcache_sram_ctrl_pkg;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

  localparam int MAX_DW = 512;
  localparam int MAX_BW = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] be_to_mask(
    input logic [MAX_BW-1:0] be
  );
    logic [MAX_DW-1:0] m;
    for (int i = 0; i < MAX_DW; i++) begin
      m[i] = be[i/8];
    end
    return m;
  endfunction

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// Synchronous FIFO holding SRAM read words awaiting the consumer.
// Caller guarantees no push when full and no pop when empty.
module hpdcache_sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= nxt(r_wptr);
      if (pop)  r_rptr <= nxt(r_rptr);
      if (push && !pop)
        r_count <= r_count + CW'(1);
      else if (pop && !push)
        r_count <= r_count - CW'(1);
    end
  end

  assign rdata = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/hpdcache_sram_wmask_req_ctrl.sv
// Front-end for a single-port bit-masked SRAM: zero-fill sweep,
// credit-gated request port and a fall-through read response buffer.
module hpdcache_sram_wmask_req_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE      = 4,
  parameter int DATA_SIZE      = 32,
  parameter int DEPTH          = 2**ADDR_SIZE,
  parameter int RSP_FIFO_DEPTH = 2,
  parameter int INIT_EN        = 1,
  localparam int BE_W = DATA_SIZE / 8,
  localparam int CW   = $clog2(RSP_FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  input  logic [BE_W-1:0]      req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 init_done,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0] sram_wdata,
  output logic [DATA_SIZE-1:0] sram_wmask,
  input  logic [DATA_SIZE-1:0] sram_rdata
);

  ctrl_state_e          r_state;
  ctrl_state_e          w_state_nxt;
  logic [ADDR_SIZE-1:0] r_init_cnt;
  logic                 r_rd_pending;

  logic                 w_run;
  logic                 w_credit;
  logic                 w_accept;
  logic [DATA_SIZE-1:0] w_mask;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [DATA_SIZE-1:0] w_head;
  logic                 w_push;
  logic                 w_pop;

  assign w_run    = (r_state == RUN) && !rst;
  assign w_credit = 32'(w_count) + 32'(r_rd_pending)
                    < 32'(RSP_FIFO_DEPTH);
  assign w_accept = req_valid && req_ready;
  assign w_mask   = DATA_SIZE'(be_to_mask(MAX_BW'(req_be)));

  assign req_ready = w_run && w_credit;
  assign init_done = w_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= (INIT_EN != 0) ? INIT : RUN;
      r_init_cnt   <= '0;
      r_rd_pending <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_pending <= w_accept && !req_we;
      if (r_state == INIT)
        r_init_cnt <= r_init_cnt + ADDR_SIZE'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    sram_cs     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = req_addr;
    sram_wdata  = req_wdata;
    sram_wmask  = '0;
    unique case (r_state)
      INIT: begin
        // Outputs stay quiet while reset is held
        sram_cs    = !rst;
        sram_we    = !rst;
        sram_addr  = r_init_cnt;
        sram_wdata = '0;
        sram_wmask = '1;
        if (r_init_cnt == ADDR_SIZE'(DEPTH - 1))
          w_state_nxt = RUN;
      end
      RUN: begin
        sram_cs = w_accept;
        sram_we = w_accept && req_we;
        if (w_accept && req_we)
          sram_wmask = w_mask;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Empty buffer: the SRAM word bypasses straight to the consumer
  assign rsp_valid = !w_empty || r_rd_pending;
  assign rsp_rdata = w_empty ? sram_rdata : w_head;
  assign w_pop     = !w_empty && rsp_ready;
  assign w_push    = r_rd_pending && !(w_empty && rsp_ready);

  hpdcache_sram_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH (DATA_SIZE)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (sram_rdata),
    .rdata (w_head),
    .empty (w_empty),
    .count (w_count)
  );

endmodule

// File: tb/tb_hpdcache_sram_wmask_req_ctrl.sv
// Randomised and directed bench for the masked-SRAM request front-end,
// with a transaction-level memory/response model and an SRAM macro model.
module tb_hpdcache_sram_wmask_req_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int FD = 2;
  localparam int ND = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_wmask;
  logic [DW-1:0] sram_rdata;

  always #5 clk = ~clk;

  hpdcache_sram_wmask_req_ctrl #(
    .ADDR_SIZE      (AW),
    .DATA_SIZE      (DW),
    .DEPTH          (ND),
    .RSP_FIFO_DEPTH (FD),
    .INIT_EN        (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .sram_rdata (sram_rdata)
  );

  // SRAM macro: bit-masked write, one-cycle read latency
  logic [DW-1:0] mem [ND];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we)
        mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask)
                        | (sram_wdata & sram_wmask);
      else
        sram_rdata <= mem[sram_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k = 0;

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [ND];

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h cyc %0d",
               n, a, e, cyc);
    end
  endtask

  task automatic chk1(input string n,
                      input logic a,
                      input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b cyc %0d",
               n, a, e, cyc);
    end
  endtask

  // Reference: outstanding reads = accepted but not yet consumed
  always @(negedge clk) begin
    logic [DW-1:0] m;
    logic          er;
    logic          ev;
    logic          acc;
    if (rst) begin
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_cs", sram_cs, 1'b0);
      chk1("rst_we", sram_we, 1'b0);
      chk1("rst_init_done", init_done, 1'b0);
      q.delete();
      k = 0;
    end else if (k < ND) begin
      if (k == 0)
        for (int i = 0; i < ND; i++) ref_mem[i] = '0;
      chk1("init_cs", sram_cs, 1'b1);
      chk1("init_we", sram_we, 1'b1);
      chk("init_addr", 32'(sram_addr), 32'(k));
      chk("init_wdata", sram_wdata, 32'h0);
      chk("init_wmask", sram_wmask, 32'hFFFF_FFFF);
      chk1("init_ready", req_ready, 1'b0);
      chk1("init_done_lo", init_done, 1'b0);
      chk1("init_rsp_valid", rsp_valid, 1'b0);
      k++;
    end else begin
      er = (q.size() < FD);
      ev = (q.size() > 0) && (q[0].c < cyc);
      chk1("init_done", init_done, 1'b1);
      chk1("req_ready", req_ready, er);
      chk1("rsp_valid", rsp_valid, ev);
      if (ev && rsp_ready) begin
        chk("rsp_rdata", rsp_rdata, q[0].d);
        void'(q.pop_front());
      end
      acc = req_valid && er;
      chk1("sram_cs", sram_cs, acc);
      if (acc) begin
        chk1("sram_we", sram_we, req_we);
        chk("sram_addr", 32'(sram_addr), 32'(req_addr));
        if (req_we) begin
          m = '0;
          for (int b = 0; b < BW; b++)
            m[8*b +: 8] = {8{req_be[b]}};
          chk("wr_wmask", sram_wmask, m);
          chk("wr_wdata", sram_wdata, req_wdata);
          for (int b = 0; b < BW; b++)
            if (req_be[b])
              ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        end else begin
          chk("rd_wmask", sram_wmask, 32'h0);
          q.push_back('{c: cyc, d: ref_mem[req_addr]});
        end
      end
    end
    cyc++;
  end

  task automatic set_req(input logic v,
                         input logic we,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic wait_acc(input string n);
    logic got;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk1(n, got, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Sweep: cycle 15 still in init, cycle 16 running
    repeat (15) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("t1_ready_c15", req_ready, 1'b0);
    chk("t1_addr_c15", 32'(sram_addr), 32'd15);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("t1_done", init_done, 1'b1);
    chk1("t1_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Masked write then immediate read-back
    set_req(1'b1, 1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101);
    wait_acc("t2_wr");
    set_req(1'b1, 1'b0, 4'd3, '0, '0);
    wait_acc("t2_rd");
    @(negedge clk);
    chk1("t2_valid", rsp_valid, 1'b1);
    chk("t2_rdata", rsp_rdata, 32'h00BB_00DD);
    @(posedge clk);
    #1;

    // Backpressure: third read held until the consumer drains
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 4'd1, '0, '0);
    wait_acc("t3_rd1");
    set_req(1'b1, 1'b0, 4'd2, '0, '0);
    wait_acc("t3_rd2");
    set_req(1'b1, 1'b0, 4'd3, '0, '0);
    repeat (3) begin
      @(negedge clk);
      chk1("t3_held", req_ready, 1'b0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_acc("t3_rd3");
    repeat (4) @(posedge clk);
    #1;

    // Writes stall on credits too
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 4'd5, '0, '0);
    wait_acc("t4_rd5");
    set_req(1'b1, 1'b0, 4'd6, '0, '0);
    wait_acc("t4_rd6");
    set_req(1'b1, 1'b1, 4'd7, 32'h1234_5678, 4'b1111);
    @(negedge clk);
    chk1("t4_ready_lo", req_ready, 1'b0);
    chk1("t4_cs_lo", sram_cs, 1'b0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk1("t4_ready_hi", req_ready, 1'b1);
    chk1("t4_cs_hi", sram_cs, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Streaming reads, one per cycle
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b0, AW'($urandom), '0, '0);
      @(negedge clk);
      chk1("t5_stream", req_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic
    repeat (400) begin
      set_req(1'($urandom_range(0, 3) != 0),
              1'($urandom),
              AW'($urandom),
              DW'($urandom),
              BW'($urandom));
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset while two words are buffered
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 4'd9, '0, '0);
    wait_acc("t6_rd9");
    set_req(1'b1, 1'b0, 4'd10, '0, '0);
    wait_acc("t6_rd10");
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("t6_valid_full", rsp_valid, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk1("t6_rst_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t6_sweep0", 32'(sram_addr), 32'd0);
    chk1("t6_empty", rsp_valid, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    set_req(1'b1, 1'b0, 4'd3, '0, '0);
    wait_acc("t6_rd3");
    @(negedge clk);
    chk("t6_zeroed", rsp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
